// File: rtl/lane_fsm_tmr.sv
// Multi-lane triple-modular-redundant state pipeline with majority voting,
// optional inter-stage scrubbing, per-lane mismatch flags and upset counters.
module lane_fsm_tmr #(
  parameter int IO_SIZE_G   = 3,
  parameter int STEPS_G     = 1,
  parameter int LANES_G     = 4,
  parameter int CNT_WIDTH_G = 8,
  parameter logic [IO_SIZE_G-1:0] IDLE  = IO_SIZE_G'(0),
  parameter logic [IO_SIZE_G-1:0] S1_A  = IO_SIZE_G'(1),
  parameter logic [IO_SIZE_G-1:0] S1_B  = IO_SIZE_G'(2),
  parameter logic [IO_SIZE_G-1:0] S1_C  = IO_SIZE_G'(3),
  parameter logic [IO_SIZE_G-1:0] S2_A  = IO_SIZE_G'(4),
  parameter logic [IO_SIZE_G-1:0] S2_B  = IO_SIZE_G'(5),
  parameter logic [IO_SIZE_G-1:0] S2_C  = IO_SIZE_G'(6),
  parameter logic [IO_SIZE_G-1:0] ERROR = IO_SIZE_G'(7),
  parameter logic [IO_SIZE_G-1:0] RESET_STATE_G   = IDLE,
  parameter logic [IO_SIZE_G-1:0] DEFAULT_STATE_G = ERROR
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [LANES_G*IO_SIZE_G-1:0]     data_i,
  input  logic                             correct_i,
  input  logic [3*LANES_G*IO_SIZE_G-1:0]   inject_i,
  input  logic                             clr_cnt_i,
  output logic [LANES_G*IO_SIZE_G-1:0]     data_o,
  output logic [LANES_G-1:0]               mismatch_o,
  output logic [LANES_G*CNT_WIDTH_G-1:0]   upset_cnt_o
);

  typedef logic [IO_SIZE_G-1:0] state_t;

  // Stage index 0 is the first stage, STEPS_G-1 the last (FSM) stage.
  state_t s_q [LANES_G][3][STEPS_G];
  state_t s_d [LANES_G][3][STEPS_G];
  logic [CNT_WIDTH_G-1:0] cnt_q [LANES_G];

  function automatic state_t next_state(input state_t x);
    case (x)
      IDLE:    next_state = S1_A;
      S1_A:    next_state = S1_B;
      S1_B:    next_state = S1_C;
      S1_C:    next_state = S2_A;
      S2_A:    next_state = S2_B;
      S2_B:    next_state = S2_C;
      S2_C:    next_state = IDLE;
      default: next_state = DEFAULT_STATE_G;
    endcase
  endfunction

  function automatic state_t vote(input state_t a, input state_t b, input state_t c);
    vote = (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    s_d = s_q;
    for (int l = 0; l < LANES_G; l++) begin
      for (int r = 0; r < 3; r++) begin
        // First stage: shared lane input, FSM applied only if it is also the last stage.
        if (STEPS_G == 1)
          s_d[l][r][0] = next_state(data_i[l*IO_SIZE_G +: IO_SIZE_G]);
        else
          s_d[l][r][0] = data_i[l*IO_SIZE_G +: IO_SIZE_G];
        s_d[l][r][0] = s_d[l][r][0] ^ inject_i[(l*3+r)*IO_SIZE_G +: IO_SIZE_G];
        for (int k = 1; k < STEPS_G; k++) begin
          state_t x;
          if (correct_i)
            x = vote(s_q[l][0][k-1], s_q[l][1][k-1], s_q[l][2][k-1]);
          else
            x = s_q[l][r][k-1];
          s_d[l][r][k] = (k == STEPS_G-1) ? next_state(x) : x;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < LANES_G; l++)
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < STEPS_G; k++)
            s_q[l][r][k] <= RESET_STATE_G;
    end else begin
      s_q <= s_d;
    end
  end

  always_comb begin
    data_o      = '0;
    mismatch_o  = '0;
    upset_cnt_o = '0;
    for (int l = 0; l < LANES_G; l++) begin
      data_o[l*IO_SIZE_G +: IO_SIZE_G] =
        vote(s_q[l][0][STEPS_G-1], s_q[l][1][STEPS_G-1], s_q[l][2][STEPS_G-1]);
      mismatch_o[l] = (s_q[l][0][STEPS_G-1] != s_q[l][1][STEPS_G-1]) ||
                      (s_q[l][1][STEPS_G-1] != s_q[l][2][STEPS_G-1]);
      upset_cnt_o[l*CNT_WIDTH_G +: CNT_WIDTH_G] = cnt_q[l];
    end
  end

  // Counters sample the current mismatch flag, so a count lags its flag by one cycle.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < LANES_G; l++) begin
      if (rst_i || clr_cnt_i)
        cnt_q[l] <= '0;
      else if (mismatch_o[l] && (cnt_q[l] != {CNT_WIDTH_G{1'b1}}))
        cnt_q[l] <= cnt_q[l] + 1'b1;
    end
  end

endmodule
